// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_detector_param: runtime-loadable serial pattern detector, overlap or  |
// | non-overlap, registered match pulse and saturating match counter.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seq_detector_param #(
  parameter int                 MAX_LEN       = 8,
  parameter int                 CNT_W         = 8,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = 8'b0000_1101,
  parameter int                 RESET_LEN     = 4,
  parameter bit                 RESET_OVERLAP = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic                           i,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           out,
  output logic [CNT_W-1:0]               match_count,
  output logic                           count_sat,
  output logic                           cfg_err
);

  localparam int               c_lw    = $clog2(MAX_LEN+1);
  localparam logic [c_lw-1:0]  c_max   = c_lw'(MAX_LEN);
  localparam logic [c_lw-1:0]  c_rlen  = c_lw'(RESET_LEN);

  logic [MAX_LEN-1:0] r_pattern;
  logic [c_lw-1:0]    r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [c_lw-1:0]    r_fill;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN:0]   w_mask;
  logic [c_lw:0]      w_fill_p1;
  logic               w_match;
  logic [c_lw-1:0]    w_fill_inc;
  logic [c_lw-1:0]    w_len_new;
  logic               w_len_bad;

  assign w_accept   = i_valid && !cfg_load;
  assign w_window   = {r_hist[MAX_LEN-2:0], i};
  // Mask keeps only the low r_len bits of the window/pattern comparison.
  assign w_mask     = ((MAX_LEN+1)'(1) << r_len) - (MAX_LEN+1)'(1);
  assign w_fill_p1  = {1'b0, r_fill} + (c_lw+1)'(1);
  assign w_match    = w_accept && (w_fill_p1 >= {1'b0, r_len}) &&
                      (((w_window ^ r_pattern) & w_mask[MAX_LEN-1:0]) == '0);
  assign w_fill_inc = (r_fill == c_max) ? r_fill : r_fill + c_lw'(1);

  always_comb begin
    w_len_new = cfg_len;
    w_len_bad = 1'b0;
    if (cfg_len == '0) begin
      w_len_new = c_lw'(1);
      w_len_bad = 1'b1;
    end else if (cfg_len > c_max) begin
      w_len_new = c_max;
      w_len_bad = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pattern <= RESET_PATTERN;
      r_len     <= c_rlen;
      r_overlap <= RESET_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      out       <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      out     <= w_match;
      cfg_err <= cfg_load && w_len_bad;
      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= w_len_new;
        r_overlap <= cfg_overlap;
        r_fill    <= '0;
      end else if (i_valid) begin
        r_hist <= w_window;
        // Non-overlap restarts the fill so the next match needs fresh bits.
        if (!r_overlap && w_match) r_fill <= '0;
        else                       r_fill <= w_fill_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= '0;
    end else if (w_match && !(&match_count)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  assign count_sat = &match_count;

endmodule
`default_nettype wire
